fpu_issue_arb: RTL
==================

// Module: fpu_issue_arb
// PURPOSE
//  Shares one fixed-latency fpu pipeline between NREQ requesters: round-robin issue, one op per cycle.
//  Tracks in-flight ops in a tag shift register aligned to the fpu pipeline.
//  Steers each result plus its exception flags into a per-requester response FIFO.
//  Per-requester credits prevent FIFO overflow, because the fpu pipeline cannot stall.
// PARAMETERS
//  NREQ      2  number of requesters (2..8)
//  FPU_LAT   5  edges from launching fpu_* to the edge where the matching fpu_out/fpu_flags are sampled
//  RSP_DEPTH 4  entries per response FIFO; also the per-requester outstanding limit (power of 2, >=2)
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  rst_n      in   1          asynchronous active-low reset
//  req_valid  in   NREQ       request valid, one bit per requester
//  req_ready  out  NREQ       request accepted this cycle (one-hot or zero)
//  req_op     in   NREQ*3     fpu opcode per requester (0 add,1 sub,2 mul,3 div,4/5 convert)
//  req_rmode  in   NREQ*2     rounding mode per requester
//  req_opa    in   NREQ*32    operand A per requester
//  req_opb    in   NREQ*32    operand B per requester
//  rsp_valid  out  NREQ       response FIFO non-empty
//  rsp_ready  in   NREQ       response consumed
//  rsp_data   out  NREQ*32    FIFO head result
//  rsp_flags  out  NREQ*8     FIFO head {inf,snan,qnan,ine,overflow,underflow,zero,div_by_zero}
//  fpu_op     out  3          to fpu, registered
//  fpu_rmode  out  2          to fpu, registered
//  fpu_opa    out  32         to fpu, registered
//  fpu_opb    out  32         to fpu, registered
//  fpu_out    in   32         fpu result
//  fpu_flags  in   8          fpu status, same order as rsp_flags
//  busy       out  1          any op in flight or any FIFO non-empty
// BEHAVIOUR
//  Reset (async, rst_n=0): tag pipe valids, FIFOs, credit counters and RR pointer are cleared.
//   Outputs at reset: fpu_* = 0, req_ready = 0, rsp_valid = 0, busy = 0.
//   Reset mid-operation discards all in-flight ops; results arriving afterwards are ignored.
//  Eligibility: eligible[i] = req_valid[i] & (cnt[i] < RSP_DEPTH).
//   cnt[i] = ops in flight for i + FIFO i occupancy.
//  Arbitration is combinational, round-robin from pointer ptr.
//   req_ready[i] = grant[i]; grant is one-hot among eligible requesters.
//   On a grant, ptr <= (granted index + 1) mod NREQ; otherwise ptr holds.
//  Issue: on the granting edge, fpu_* <= the selected request, and the tag pipe stage 0 <= {valid=1, id}.
//   No grant: fpu_* hold their value and stage 0 valid <= 0.
//  Tag pipe: FPU_LAT stages, advancing every cycle. When the last stage is valid on an edge,
//   {fpu_out, fpu_flags} is pushed into FIFO[id] on that edge.
//  Credits: cnt[i] += 1 on issue to i; cnt[i] -= 1 on rsp_valid[i] & rsp_ready[i].
//   Both in the same cycle: unchanged.
//   An overflowing push is impossible by construction; simulation asserts on push to a full FIFO.
//  FIFO: first-word fall-through, read and write pointer wrap modulo RSP_DEPTH.
//   A push to an empty FIFO gives rsp_valid the next cycle; no same-cycle bypass.
//   Push and pop in the same cycle are both performed.
//  Ordering: responses per requester are returned in issue order. There is no ordering across requesters.
//  Throughput: 1 op/cycle aggregate. Latency from req handshake to rsp_valid = FPU_LAT + 1 cycles.
// CONFIGURATION
//  FPU_ARB_STICKY_FLAGS_EN defined:
//   adds ports fflags out NREQ*8 and fflags_clr in NREQ.
//   fflags[i] ORs in the flags of every pushed result for requester i, updated on the same edge as the push.
//   fflags_clr[i] zeroes fflags[i]. If clear and a push coincide, fflags[i] <= the pushed flags only.
//   fflags resets to 0.
//  FPU_ARB_STICKY_FLAGS_EN undefined: the ports and logic are absent; everything else is unchanged.
// STRUCTURE
//  Shared package fpu_pkg: FPU_OP_* opcode constants, RMODE_* constants, FLAG_* bit indices,
//   fpu_flags_t (8b), fpu_rsp_t {data[31:0], flags}.
//  One sub-module, fpu_rsp_fifo: width 40, depth RSP_DEPTH, FWFT, instantiated NREQ times.
//  The arbiter, tag pipe and credit counters stay in this module.
// TESTING
//  Stub fpu: a FPU_LAT-deep pipe returning out=opa^opb and flags=op, to check steering.
//  1 Single req0 add, opa=3F800000, opb=40000000 -> fpu_op=0 one edge later;
//    rsp_valid[0] at +6 cycles, data=7F800000, flags=00.
//  2 req0 and req1 held valid, rsp_ready=1 -> grants alternate 0,1,0,1; one issue per cycle; no response lost.
//  3 req0 held valid with rsp_ready[0]=0 -> exactly 4 grants, then req_ready[0]=0.
//    Raise rsp_ready -> issue resumes the cycle after the first pop.
//  4 Pulse rst_n low while 3 ops are in flight -> rsp_valid stays 0 after release; cnt=0; busy=0.
//  5 Pop and response push on the same edge with the FIFO holding 1 entry -> occupancy stays 1; data order preserved.
//  6 (sticky EN) Results with flags 04 then 01 -> fflags[0]=05.
//    fflags_clr coinciding with a push of 02 -> fflags[0]=02.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU arbiter types: opcodes, rounding modes, flag bit positions and the response word.
package fpu_pkg;

    localparam logic [2:0] FPU_OP_ADD = 3'd0;
    localparam logic [2:0] FPU_OP_SUB = 3'd1;
    localparam logic [2:0] FPU_OP_MUL = 3'd2;
    localparam logic [2:0] FPU_OP_DIV = 3'd3;
    localparam logic [2:0] FPU_OP_I2F = 3'd4;
    localparam logic [2:0] FPU_OP_F2I = 3'd5;

    localparam logic [1:0] RMODE_NEAREST = 2'd0;
    localparam logic [1:0] RMODE_ZERO    = 2'd1;
    localparam logic [1:0] RMODE_POS_INF = 2'd2;
    localparam logic [1:0] RMODE_NEG_INF = 2'd3;

    localparam int FLAG_DIV_BY_ZERO = 0;
    localparam int FLAG_ZERO        = 1;
    localparam int FLAG_UNDERFLOW   = 2;
    localparam int FLAG_OVERFLOW    = 3;
    localparam int FLAG_INE         = 4;
    localparam int FLAG_QNAN        = 5;
    localparam int FLAG_SNAN        = 6;
    localparam int FLAG_INF         = 7;

    typedef logic [7:0] fpu_flags_t;

    typedef struct packed {
        logic [31:0] data;
        fpu_flags_t  flags;
    } fpu_rsp_t;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Per-requester first-word-fall-through response queue of fpu_rsp_t, DEPTH entries.
// Latency: a push is visible at the head one cycle later; no write-to-read bypass.
// Backpressure: none; the producer must never push when full (asserted).
module fpu_rsp_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  fpu_rsp_t push_dat,
    input  logic     pop,
    output logic     vld,
    output fpu_rsp_t head
);

    localparam int AW = $clog2(DEPTH);

    fpu_rsp_t      mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_pop;

    assign do_pop = pop & vld;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    assign vld  = (count != '0);
    assign head = mem[rptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == (AW+1)'(DEPTH))));

endmodule

// File: rtl/fpu_issue_arb.sv
// Round-robin issue of NREQ requesters onto one fixed-latency FPU; sticky flags under FPU_ARB_STICKY_FLAGS_EN.
// Latency: request handshake to rsp_valid is FPU_LAT+1 cycles; one issue per cycle aggregate.
// Backpressure: per-requester credits (in flight + queued <= RSP_DEPTH) drop req_ready; the FPU never stalls.
module fpu_issue_arb
    import fpu_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int FPU_LAT   = 5,
    parameter int RSP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*3-1:0]  req_op,
    input  logic [NREQ*2-1:0]  req_rmode,
    input  logic [NREQ*32-1:0] req_opa,
    input  logic [NREQ*32-1:0] req_opb,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [NREQ*32-1:0] rsp_data,
    output logic [NREQ*8-1:0]  rsp_flags,
`ifdef FPU_ARB_STICKY_FLAGS_EN
    output logic [NREQ*8-1:0]  fflags,
    input  logic [NREQ-1:0]    fflags_clr,
`endif
    output logic [2:0]         fpu_op,
    output logic [1:0]         fpu_rmode,
    output logic [31:0]        fpu_opa,
    output logic [31:0]        fpu_opb,
    input  logic [31:0]        fpu_out,
    input  logic [7:0]         fpu_flags,
    output logic               busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(RSP_DEPTH) + 1;

    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    push;
    logic [NREQ-1:0]    pop;
    logic               gnt_any;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     rr_idx;
    logic [IDW:0]       rr_sum;
    logic [CW-1:0]      cnt [NREQ];
    logic [FPU_LAT-1:0] tag_vld;
    logic [IDW-1:0]     tag_id [FPU_LAT];
    fpu_rsp_t           push_rsp;

    // cnt covers both in-flight ops and queued responses, so a grant always has a FIFO slot waiting.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = rst_n & req_valid[i] & (cnt[i] < CW'(RSP_DEPTH));
        end
    end

    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_sum  = '0;
        rr_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_sum = {1'b0, ptr} + (IDW+1)'(k);
            if (rr_sum >= (IDW+1)'(NREQ)) begin
                rr_sum = rr_sum - (IDW+1)'(NREQ);
            end
            rr_idx = rr_sum[IDW-1:0];
            if (!gnt_any && eligible[rr_idx]) begin
                gnt_any        = 1'b1;
                gnt_idx        = rr_idx;
                grant[rr_idx]  = 1'b1;
            end
        end
    end

    assign req_ready = grant;
    assign pop       = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            fpu_op    <= '0;
            fpu_rmode <= '0;
            fpu_opa   <= '0;
            fpu_opb   <= '0;
            tag_vld   <= '0;
            for (int s = 0; s < FPU_LAT; s++) begin
                tag_id[s] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (gnt_any) begin
                ptr       <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                fpu_op    <= req_op[int'(gnt_idx)*3 +: 3];
                fpu_rmode <= req_rmode[int'(gnt_idx)*2 +: 2];
                fpu_opa   <= req_opa[int'(gnt_idx)*32 +: 32];
                fpu_opb   <= req_opb[int'(gnt_idx)*32 +: 32];
            end
            // Stage k holds the requester id of the op launched k+1 edges ago.
            tag_vld   <= {tag_vld[FPU_LAT-2:0], gnt_any};
            tag_id[0] <= gnt_idx;
            for (int s = 1; s < FPU_LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && !pop[i]) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (!grant[i] && pop[i]) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    always_comb begin
        push = '0;
        if (tag_vld[FPU_LAT-1]) begin
            push[tag_id[FPU_LAT-1]] = 1'b1;
        end
    end

    assign push_rsp = '{data: fpu_out, flags: fpu_flags};

    for (genvar i = 0; i < NREQ; i++) begin : g_rsp
        fpu_rsp_t head;

        fpu_rsp_fifo #(
            .DEPTH (RSP_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push[i]),
            .push_dat (push_rsp),
            .pop      (pop[i]),
            .vld      (rsp_valid[i]),
            .head     (head)
        );

        assign rsp_data[i*32 +: 32] = head.data;
        assign rsp_flags[i*8 +: 8]  = head.flags;
    end

`ifdef FPU_ARB_STICKY_FLAGS_EN
    // A clear coinciding with a push keeps only the new flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (fflags_clr[i]) begin
                    fflags[i*8 +: 8] <= push[i] ? fpu_flags : 8'h00;
                end else if (push[i]) begin
                    fflags[i*8 +: 8] <= fflags[i*8 +: 8] | fpu_flags;
                end
            end
        end
    end
`endif

    assign busy = (|tag_vld) | (|rsp_valid);

endmodule
